// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP camera init sequencer: table entry markers,
// state encoding and the entry decoder.
package dvp_pkg;

  localparam logic [7:0] SEQ_REG_END   = 8'hFF;
  localparam logic [7:0] SEQ_VAL_END   = 8'hFF;
  localparam logic [7:0] SEQ_REG_DELAY = 8'hFE;
  localparam logic [7:0] DVP_DEV_ADDR  = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DELAY    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    ENT_WRITE = 2'd0,
    ENT_DELAY = 2'd1,
    ENT_END   = 2'd2
  } entry_kind_e;

  function automatic entry_kind_e decode_entry(input logic [15:0] entry);
    entry_kind_e kind;
    if ((entry[15:8] == SEQ_REG_END) && (entry[7:0] == SEQ_VAL_END)) begin
      kind = ENT_END;
    end else if (entry[15:8] == SEQ_REG_DELAY) begin
      kind = ENT_DELAY;
    end else begin
      kind = ENT_WRITE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/dvp_ms_timer.sv
// Millisecond delay timer: a 1 ms prescaler feeding an 8-bit ms down-counter.
// expired is high in the last clock of the loaded interval (ms * CLK_FREQ_HZ/1000 clks).
module dvp_ms_timer #(
  parameter int CLK_FREQ_HZ = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expired
);

  localparam int PRESC = CLK_FREQ_HZ / 1000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(PRESC - 1);
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};

  logic [PW-1:0] pre_r;
  logic [7:0]    ms_r;
  logic          run_r;

  assign expired = run_r && (ms_r == 8'd1) && (pre_r == PRE_ZERO);

  // Prescaler and ms counter; a load restarts the prescaler from the top.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_r <= PRE_ZERO;
      ms_r  <= 8'd0;
      run_r <= 1'b0;
    end else if (load) begin
      pre_r <= PRE_TOP;
      ms_r  <= ms;
      run_r <= (ms != 8'd0);
    end else if (run_r) begin
      if (pre_r == PRE_ZERO) begin
        pre_r <= PRE_TOP;
        ms_r  <= ms_r - 8'd1;
        run_r <= (ms_r != 8'd1);
      end else begin
        pre_r <= pre_r - PW'(1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

endmodule

// File: rtl/dvp_sccb_init_seq.sv
// Table-driven SCCB init sequencer: walks {reg, value} entries from a registered
// ROM and issues writes, ms delays and end markers, retrying NACKed writes.
module dvp_sccb_init_seq
  import dvp_pkg::*;
#(
  parameter int         ROM_AW      = 8,
  parameter int         CLK_FREQ_HZ = 25000000,
  parameter logic [7:0] DEV_ADDR    = DVP_DEV_ADDR,
  parameter int         MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_rddata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_err
);

  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] PTR_LAST  = {ROM_AW{1'b1}};
  localparam logic [ROM_AW-1:0] PTR_ZERO  = {ROM_AW{1'b0}};

  seq_state_e        state_r, state_nxt_s, adv_state_s;
  entry_kind_e       entry_kind_s;
  logic [ROM_AW-1:0] ptr_r, ptr_nxt_s, ptr_adv_s;
  logic [ROM_AW-1:0] err_index_r, err_index_nxt_s;
  logic              rd_phase_r, rd_phase_nxt_s;
  logic [RW-1:0]     retry_r, retry_nxt_s;
  logic [7:0]        cmd_reg_r, cmd_reg_nxt_s, cmd_data_r, cmd_data_nxt_s;
  logic              busy_r, done_r, error_r, cmd_valid_r;
  logic              timer_load_s, timer_expired_s;

  dvp_ms_timer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_ms_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load_s),
    .ms      (rom_rddata[7:0]),
    .expired (timer_expired_s)
  );

  // The table ends at the last address even without an END entry; never wrap.
  assign ptr_adv_s   = (ptr_r == PTR_LAST) ? ptr_r : (ptr_r + ROM_AW'(1));
  assign adv_state_s = (ptr_r == PTR_LAST) ? ST_DONE : ST_READ;

  // Next-state and datapath decode.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    rd_phase_nxt_s  = rd_phase_r;
    retry_nxt_s     = retry_r;
    cmd_reg_nxt_s   = cmd_reg_r;
    cmd_data_nxt_s  = cmd_data_r;
    err_index_nxt_s = err_index_r;
    timer_load_s    = 1'b0;
    entry_kind_s    = decode_entry(rom_rddata);
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_nxt_s    = ST_READ;
          ptr_nxt_s      = PTR_ZERO;
          rd_phase_nxt_s = 1'b0;
          retry_nxt_s    = {RW{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_READ: begin
        // Phase 0 lets the address settle into the ROM; phase 1 sees its data.
        if (!rd_phase_r) begin
          rd_phase_nxt_s = 1'b1;
        end else begin
          rd_phase_nxt_s = 1'b0;
          case (entry_kind_s)
            ENT_END: begin
              state_nxt_s = ST_DONE;
            end
            ENT_DELAY: begin
              if (rom_rddata[7:0] == 8'd0) begin
                state_nxt_s = adv_state_s;
                ptr_nxt_s   = ptr_adv_s;
              end else begin
                state_nxt_s  = ST_DELAY;
                timer_load_s = 1'b1;
              end
            end
            default: begin
              state_nxt_s    = ST_ISSUE;
              cmd_reg_nxt_s  = rom_rddata[15:8];
              cmd_data_nxt_s = rom_rddata[7:0];
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_nxt_s = ST_WAIT_RSP;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_RSP: begin
        if (!rsp_valid) begin
          state_nxt_s = ST_WAIT_RSP;
        end else if (!rsp_err) begin
          retry_nxt_s = {RW{1'b0}};
          state_nxt_s = adv_state_s;
          ptr_nxt_s   = ptr_adv_s;
        end else if (retry_r < RETRY_MAX) begin
          retry_nxt_s = retry_r + RW'(1);
          state_nxt_s = ST_ISSUE;
        end else begin
          err_index_nxt_s = ptr_r;
          state_nxt_s     = ST_FAIL;
        end
      end
      ST_DELAY: begin
        if (timer_expired_s) begin
          state_nxt_s = adv_state_s;
          ptr_nxt_s   = ptr_adv_s;
        end else begin
          state_nxt_s = ST_DELAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and flag registers; flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= PTR_ZERO;
      rd_phase_r  <= 1'b0;
      retry_r     <= {RW{1'b0}};
      cmd_reg_r   <= 8'd0;
      cmd_data_r  <= 8'd0;
      err_index_r <= PTR_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cmd_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      rd_phase_r  <= rd_phase_nxt_s;
      retry_r     <= retry_nxt_s;
      cmd_reg_r   <= cmd_reg_nxt_s;
      cmd_data_r  <= cmd_data_nxt_s;
      err_index_r <= err_index_nxt_s;
      busy_r      <= (state_nxt_s == ST_READ) || (state_nxt_s == ST_ISSUE) ||
                     (state_nxt_s == ST_WAIT_RSP) || (state_nxt_s == ST_DELAY);
      done_r      <= (state_nxt_s == ST_DONE);
      error_r     <= (state_nxt_s == ST_FAIL);
      cmd_valid_r <= (state_nxt_s == ST_ISSUE);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_index = err_index_r;
  assign rom_addr  = ptr_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_dev   = DEV_ADDR;
  assign cmd_reg   = cmd_reg_r;
  assign cmd_data  = cmd_data_r;

endmodule

// File: tb/tb_dvp_sccb_init_seq.sv
// Directed bench for dvp_sccb_init_seq: a 1 kHz-prescaler instance for the main
// flows and a 3 kHz one to exercise the ms prescaler in delay entries.
module tb_dvp_sccb_init_seq;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n, start, start_p, cmd_ready, rsp_valid, rsp_err;
  logic          busy, done, error, cmd_valid;
  logic [AW-1:0] err_index, rom_addr;
  logic [15:0]   rom_rddata;
  logic [7:0]    cmd_dev, cmd_reg, cmd_data;
  logic          busy_p, done_p, error_p, cmd_valid_p;
  logic [AW-1:0] err_index_p, rom_addr_p;
  logic [15:0]   rom_rddata_p;
  logic [7:0]    cmd_dev_p, cmd_reg_p, cmd_data_p;

  logic [15:0] rom [4];
  int          checks = 0;
  int          errors = 0;
  int          cmd_count = 0;
  int          err_reg_hits = 0;
  int          rsp_cnt = 0;
  logic [7:0]  log_dev [16];
  logic [7:0]  log_reg [16];
  logic [7:0]  log_data [16];
  logic [7:0]  last_reg = 8'h00;
  logic [7:0]  err_reg_sel = 8'hEE;
  logic        seen_last, wrapped;

  dvp_sccb_init_seq #(.ROM_AW(AW), .CLK_FREQ_HZ(1000), .DEV_ADDR(8'h42), .MAX_RETRY(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .rom_addr(rom_addr), .rom_rddata(rom_rddata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err));

  dvp_sccb_init_seq #(.ROM_AW(AW), .CLK_FREQ_HZ(3000), .DEV_ADDR(8'h42), .MAX_RETRY(3)) dut_p (
    .clk(clk), .reset_n(reset_n), .start(start_p), .busy(busy_p), .done(done_p), .error(error_p),
    .err_index(err_index_p), .rom_addr(rom_addr_p), .rom_rddata(rom_rddata_p),
    .cmd_valid(cmd_valid_p), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev_p), .cmd_reg(cmd_reg_p),
    .cmd_data(cmd_data_p), .rsp_valid(rsp_valid), .rsp_err(rsp_err));

  always #20 clk = ~clk;

  // Registered ROM model: data valid one clock after the address.
  always @(posedge clk) begin
    rom_rddata   <= rom[rom_addr];
    rom_rddata_p <= rom[rom_addr_p];
  end

  // SCCB master model: logs accepts, answers 5 clks later, NACKs err_reg_sel.
  initial begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_err   = (last_reg == err_reg_sel);
        end
      end
      if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        if (cmd_count < 16) begin
          log_dev[cmd_count]  = cmd_dev;
          log_reg[cmd_count]  = cmd_reg;
          log_data[cmd_count] = cmd_data;
        end
        cmd_count++;
        last_reg = cmd_reg;
        if (cmd_reg == err_reg_sel) err_reg_hits++;
        rsp_cnt = 5;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n;
    n = 0;
    seen_last = 1'b0;
    wrapped = 1'b0;
    while (!(done === 1'b1 || error === 1'b1) && n < max) begin
      tick();
      n++;
      if (rom_addr == 2'd3) seen_last = 1'b1;
      else if (seen_last && rom_addr == 2'd0) wrapped = 1'b1;
    end
    chk("end_timeout", 32'(n < max), 32'd1);
  endtask

  initial begin
    int nb, nbp;
    logic stable;
    reset_n = 1'b0; start = 1'b0; start_p = 1'b0; cmd_ready = 1'b1;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
    tick(); tick();
    chk("rst_flags", {busy, done, error, cmd_valid}, 32'h0);
    chk("rst_fields", {cmd_reg, cmd_data, err_index, rom_addr}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Two writes then END; cmd_valid two clocks after the start edge.
    cmd_count = 0;
    pulse_start();
    chk("t1_busy", busy, 32'd1);
    chk("t1_cv_e1", cmd_valid, 32'd0);
    tick();
    chk("t1_cv_e2", cmd_valid, 32'd0);
    tick();
    chk("t1_cv_e3", cmd_valid, 32'd1);
    chk("t1_cmd0_live", {cmd_dev, cmd_reg, cmd_data}, 32'h421280);
    wait_end(200);
    chk("t1_count", cmd_count, 32'd2);
    chk("t1_cmd0", {log_dev[0], log_reg[0], log_data[0]}, 32'h421280);
    chk("t1_cmd1", {log_dev[1], log_reg[1], log_data[1]}, 32'h421101);
    chk("t1_flags", {done, busy, error}, 32'b100);

    // Delay entries: 2 ms is 2 clks on dut, 6 clks on dut_p; 0 ms adds nothing.
    rom[0] = 16'hFE02; rom[1] = 16'hFFFF;
    cmd_count = 0;
    start = 1'b1; start_p = 1'b1;
    tick();
    start = 1'b0; start_p = 1'b0;
    nb = 0; nbp = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) nb++;
      if (busy_p === 1'b1) nbp++;
      tick();
    end
    chk("t2_busy_1k", nb, 32'd6);
    chk("t2_busy_3k", nbp, 32'd10);
    chk("t2_done", {done, done_p, error, error_p}, 32'b1100);
    chk("t2_nocmd", cmd_count, 32'd0);
    rom[0] = 16'hFE00;
    start = 1'b1; start_p = 1'b1;
    tick();
    start = 1'b0; start_p = 1'b0;
    nb = 0; nbp = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) nb++;
      if (busy_p === 1'b1) nbp++;
      tick();
    end
    chk("t2_zero_1k", nb, 32'd4);
    chk("t2_zero_3k", nbp, 32'd4);
    chk("t2_p_fields", {cmd_valid_p, cmd_dev_p, cmd_reg_p, cmd_data_p, 5'd0, err_index_p}, 32'h42_0000 << 7);

    // Backpressure, with a start pulse while busy that must be ignored.
    rom[0] = 16'h3355; rom[1] = 16'hFFFF;
    cmd_ready = 1'b0;
    cmd_count = 0;
    pulse_start();
    tick(); tick();
    chk("t3_cv", cmd_valid, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      if (!(cmd_valid === 1'b1 && cmd_reg === 8'h33 && cmd_data === 8'h55)) stable = 1'b0;
    end
    start = 1'b0;
    chk("t3_stable", stable, 32'd1);
    chk("t3_noacc", cmd_count, 32'd0);
    cmd_ready = 1'b1;
    tick();
    chk("t3_cv_drop", cmd_valid, 32'd0);
    chk("t3_one_acc", cmd_count, 32'd1);
    wait_end(200);
    chk("t3_count", cmd_count, 32'd1);
    chk("t3_done", done, 32'd1);

    // Entry 3 always NACKed: 1 + 3 retries, then FAIL at index 3.
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303; rom[3] = 16'h0404;
    err_reg_sel = 8'h04; err_reg_hits = 0; cmd_count = 0;
    pulse_start();
    wait_end(400);
    chk("t4_flags", {error, done, busy}, 32'b100);
    chk("t4_err_index", err_index, 32'd3);
    chk("t4_issues", err_reg_hits, 32'd4);
    chk("t4_total", cmd_count, 32'd7);

    // Restart clears error; table has no END so it stops after entry 3.
    err_reg_sel = 8'hEE; cmd_count = 0;
    pulse_start();
    chk("t5_restart", {error, busy, 6'd0, rom_addr}, 32'h100);
    wait_end(400);
    chk("t5_flags", {done, error, busy}, 32'b100);
    chk("t5_count", cmd_count, 32'd4);
    chk("t5_last_cmd", {log_reg[3], log_data[3]}, 32'h0404);
    chk("t5_addr_end", rom_addr, 32'd3);
    chk("t5_nowrap", {seen_last, wrapped}, 32'b10);

    // Reset while a command is pending.
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    cmd_ready = 1'b0;
    pulse_start();
    tick(); tick();
    chk("t6_issue", cmd_valid, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_flags", {busy, done, error, cmd_valid}, 32'h0);
    chk("t6_rst_fields", {cmd_reg, cmd_data, err_index, rom_addr}, 32'h0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_idle", {busy, cmd_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
